// File: rtl/tpm_buf_arbiter_if.sv
// tpm_buf_arbiter_if
// Bundles the three buses around the TPM buffer arbiter:
//   dp_*  : byte-wide data-provider request/response (LPC/TIS register side)
//   wb_*  : Wishbone classic slave window onto the buffer
//   ram_* : port to the 512x32 synchronous buffer RAM
// Modports:
//   slave  - the arbiter: consumes requests and RAM read data, drives
//            responses and RAM controls
//   master - the environment: drives requests and RAM read data
interface tpm_buf_arbiter_if #(
    parameter int ADDR_W = 11
);
    // Data-provider side
    logic              dp_req_i;
    logic              dp_we_i;
    logic [ADDR_W-1:0] dp_addr_i;
    logic [7:0]        dp_wdata_i;
    logic [7:0]        dp_rdata_o;
    logic              dp_ack_o;
    logic              dp_err_o;

    // Wishbone side
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [ADDR_W-3:0] wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    // Buffer RAM side
    logic [ADDR_W-3:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [3:0]        ram_we_o;
    logic [31:0]       ram_rdata_i;

    modport slave (
        input  dp_req_i, dp_we_i, dp_addr_i, dp_wdata_i,
        output dp_rdata_o, dp_ack_o, dp_err_o,
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output ram_addr_o, ram_wdata_o, ram_we_o,
        input  ram_rdata_i
    );

    modport master (
        output dp_req_i, dp_we_i, dp_addr_i, dp_wdata_i,
        input  dp_rdata_o, dp_ack_o, dp_err_o,
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  ram_addr_o, ram_wdata_o, ram_we_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/tpm_buf_arbiter.sv
// tpm_buf_arbiter
// Shares the TPM command/response buffer RAM between the data provider and
// the CPU Wishbone window using registered ownership instead of clock muxing.
// exec_i high hands the buffer to Wishbone, low to the data provider. A
// request from the side that does not own the buffer is answered with an
// error and never reaches the RAM.
// Ports:
//   clk_i   - system clock (only clock)
//   rst_i   - synchronous active-high reset
//   exec_i  - ownership request, 1 = Wishbone, 0 = data provider
//   owner_o - current owner, 1 = Wishbone
//   bus     - tpm_buf_arbiter_if.slave (dp_*, wb_*, ram_* signals)
module tpm_buf_arbiter #(
    parameter int ADDR_W = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 exec_i,
    output logic                 owner_o,
    tpm_buf_arbiter_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state_r;
    logic        txn_wb_r;   // transaction in flight belongs to Wishbone
    logic        txn_rd_r;   // transaction in flight is a read
    logic [1:0]  lane_r;     // byte lane of a data-provider access

    logic        wb_req_s;
    logic        dp_req_s;

    assign wb_req_s = bus.wb_cyc_i & bus.wb_stb_i;
    assign dp_req_s = bus.dp_req_i;

    // Byte lane extraction from a RAM word; lane 0 is bits [7:0].
    function automatic logic [7:0] pick_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= S_IDLE;
            txn_wb_r        <= 1'b0;
            txn_rd_r        <= 1'b0;
            lane_r          <= 2'd0;
            owner_o         <= 1'b0;
            bus.dp_rdata_o  <= 8'h00;
            bus.dp_ack_o    <= 1'b0;
            bus.dp_err_o    <= 1'b0;
            bus.wb_dat_o    <= 32'h0000_0000;
            bus.wb_ack_o    <= 1'b0;
            bus.wb_err_o    <= 1'b0;
            bus.ram_addr_o  <= '0;
            bus.ram_wdata_o <= 32'h0000_0000;
            bus.ram_we_o    <= 4'b0000;
        end else begin
            // Responses are single-cycle pulses unless re-armed below.
            bus.dp_ack_o <= 1'b0;
            bus.dp_err_o <= 1'b0;
            bus.wb_ack_o <= 1'b0;
            bus.wb_err_o <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // Ownership only moves between transactions.
                    owner_o <= exec_i;
                    // Owner is checked first so a simultaneous non-owner
                    // request waits for the next IDLE pass to be errored.
                    if (exec_i && wb_req_s) begin
                        bus.ram_addr_o  <= bus.wb_adr_i;
                        bus.ram_wdata_o <= bus.wb_dat_i;
                        bus.ram_we_o    <= bus.wb_we_i ? bus.wb_sel_i : 4'b0000;
                        txn_wb_r        <= 1'b1;
                        txn_rd_r        <= ~bus.wb_we_i;
                        state_r         <= S_ISSUE;
                    end else if (!exec_i && dp_req_s) begin
                        bus.ram_addr_o  <= bus.dp_addr_i[ADDR_W-1:2];
                        bus.ram_wdata_o <= {4{bus.dp_wdata_i}};
                        bus.ram_we_o    <= bus.dp_we_i ?
                                           (4'b0001 << bus.dp_addr_i[1:0]) : 4'b0000;
                        lane_r          <= bus.dp_addr_i[1:0];
                        txn_wb_r        <= 1'b0;
                        txn_rd_r        <= ~bus.dp_we_i;
                        state_r         <= S_ISSUE;
                    end else if (exec_i && dp_req_s) begin
                        bus.dp_ack_o   <= 1'b1;
                        bus.dp_err_o   <= 1'b1;
                        bus.dp_rdata_o <= 8'hFF;
                        state_r        <= S_ERR;
                    end else if (!exec_i && wb_req_s) begin
                        bus.wb_err_o <= 1'b1;
                        state_r      <= S_ERR;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // The RAM captures on this edge; strobe the write once.
                    bus.ram_we_o <= 4'b0000;
                    state_r      <= S_WAIT;
                end
                S_WAIT: begin
                    if (txn_wb_r) begin
                        if (txn_rd_r) begin
                            bus.wb_dat_o <= bus.ram_rdata_i;
                        end else begin
                            bus.wb_dat_o <= bus.wb_dat_o;
                        end
                        bus.wb_ack_o <= 1'b1;
                    end else begin
                        if (txn_rd_r) begin
                            bus.dp_rdata_o <= pick_lane(bus.ram_rdata_i, lane_r);
                        end else begin
                            bus.dp_rdata_o <= bus.dp_rdata_o;
                        end
                        bus.dp_ack_o <= 1'b1;
                    end
                    state_r <= S_ACK;
                end
                S_ACK: begin
                    state_r <= S_IDLE;
                end
                S_ERR: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    bus.ram_we_o <= 4'b0000;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// tb_tpm_buf_arbiter
// Directed bench for tpm_buf_arbiter with a behavioural 512x32 synchronous
// RAM attached to the ram_* port. Expected values are hand-computed.
module tb_tpm_buf_arbiter;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    logic rst;
    logic exec;
    logic owner;

    int n_vec  = 0;
    int n_miss = 0;
    int we_cycles = 0;

    logic [31:0] mem [512];

    tpm_buf_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    tpm_buf_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .exec_i  (exec),
        .owner_o (owner),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM with byte enables; read data one edge late.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (bus.ram_we_o[l]) mem[bus.ram_addr_o][8*l +: 8] <= bus.ram_wdata_o[8*l +: 8];
            end
        end
        bus.ram_rdata_i <= mem[bus.ram_addr_o];
    end

    // Count clock cycles during which any RAM write enable is asserted.
    always @(posedge clk) begin
        if (bus.ram_we_o != 4'b0000) we_cycles <= we_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dp_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic err, output int lat);
        bus.dp_req_i   = 1'b1;
        bus.dp_we_i    = we;
        bus.dp_addr_i  = addr;
        bus.dp_wdata_i = wd;
        lat = 0; rd = 8'h00; err = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.dp_ack_o) begin
                lat = i; rd = bus.dp_rdata_o; err = bus.dp_err_o;
                break;
            end
        end
        bus.dp_req_i = 1'b0;
        step();
        check_eq("dp_ack_pulse", bus.dp_ack_o, 1'b0);
    endtask

    task automatic wb_txn(input logic we, input logic [3:0] sel, input logic [ADDR_W-3:0] adr,
                          input logic [31:0] dat, output logic [31:0] rd,
                          output logic ack, output logic err, output int lat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        lat = 0; rd = 32'h0; ack = 1'b0; err = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus.wb_ack_o || bus.wb_err_o) begin
                lat = i; rd = bus.wb_dat_o; ack = bus.wb_ack_o; err = bus.wb_err_o;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        step();
        check_eq("wb_resp_pulse", {bus.wb_ack_o, bus.wb_err_o}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd8;
        logic [31:0] rd32;
        logic        ack, err;
        int          lat, base, wb_at, dp_at;
        logic        dp_err_seen;

        rst = 1'b1; exec = 1'b0;
        bus.dp_req_i = 1'b0; bus.dp_we_i = 1'b0; bus.dp_addr_i = '0; bus.dp_wdata_i = 8'h00;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'b0000;
        bus.wb_adr_i = '0;   bus.wb_dat_i = 32'h0;
        step(); step();
        check_eq("rst_owner", owner, 1'b0);
        check_eq("rst_acks", {bus.dp_ack_o, bus.dp_err_o, bus.wb_ack_o, bus.wb_err_o}, 4'b0000);
        check_eq("rst_ram_we", bus.ram_we_o, 4'b0000);
        rst = 1'b0;
        step();

        // Data-provider write of 0xA5 to byte 0x006, cycle by cycle.
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b1; bus.dp_addr_i = 11'h006; bus.dp_wdata_i = 8'hA5;
        step();
        check_eq("dpw_e0_we", bus.ram_we_o, 4'b0100);
        check_eq("dpw_e0_addr", bus.ram_addr_o, 9'd1);
        check_eq("dpw_e0_wdata", bus.ram_wdata_o, 32'hA5A5_A5A5);
        step();
        check_eq("dpw_e1_we", bus.ram_we_o, 4'b0000);
        check_eq("dpw_e1_ack", bus.dp_ack_o, 1'b0);
        step();
        check_eq("dpw_e2_ack_err", {bus.dp_ack_o, bus.dp_err_o}, 2'b10);
        bus.dp_req_i = 1'b0;
        step();
        check_eq("dpw_e3_ack", bus.dp_ack_o, 1'b0);
        check_eq("dpw_mem", mem[1], 32'h00A5_0000);

        dp_txn(1'b0, 11'h006, 8'h00, rd8, err, lat);
        check_eq("dpr_data", rd8, 8'hA5);
        check_eq("dpr_err", err, 1'b0);
        check_eq("dpr_lat", lat, 3);

        // Wishbone full then partial write to the last word.
        exec = 1'b1;
        wb_txn(1'b1, 4'b1111, 9'h1FF, 32'hDEAD_BEEF, rd32, ack, err, lat);
        check_eq("wbw_ack_err", {ack, err}, 2'b10);
        check_eq("wbw_lat", lat, 3);
        check_eq("wbw_mem", mem[9'h1FF], 32'hDEAD_BEEF);

        base = we_cycles;
        wb_txn(1'b1, 4'b0011, 9'h1FF, 32'h1234_5678, rd32, ack, err, lat);
        check_eq("wbp_ack_err", {ack, err}, 2'b10);
        check_eq("wbp_mem", mem[9'h1FF], 32'hDEAD_5678);
        check_eq("wbp_we_cycles", we_cycles - base, 1);

        wb_txn(1'b0, 4'b1111, 9'h1FF, 32'h0, rd32, ack, err, lat);
        check_eq("wbr_data", rd32, 32'hDEAD_5678);
        check_eq("wbr_ack_lat", {ack, err, lat[7:0]}, {2'b10, 8'd3});

        base = we_cycles;
        wb_txn(1'b1, 4'b0000, 9'h1FF, 32'hFFFF_FFFF, rd32, ack, err, lat);
        check_eq("wbsel0_ack", {ack, err}, 2'b10);
        check_eq("wbsel0_we_cycles", we_cycles - base, 0);
        check_eq("wbsel0_mem", mem[9'h1FF], 32'hDEAD_5678);

        // Wrong-owner rejections.
        base = we_cycles;
        dp_txn(1'b0, 11'h006, 8'h00, rd8, err, lat);
        check_eq("dperr_err", err, 1'b1);
        check_eq("dperr_rdata", rd8, 8'hFF);
        check_eq("dperr_lat", lat, 1);
        check_eq("dperr_we_cycles", we_cycles - base, 0);

        exec = 1'b0;
        base = we_cycles;
        wb_txn(1'b1, 4'b1111, 9'h1FF, 32'h0000_0000, rd32, ack, err, lat);
        check_eq("wberr_ack_err", {ack, err}, 2'b01);
        check_eq("wberr_lat", lat, 1);
        check_eq("wberr_we_cycles", we_cycles - base, 0);
        check_eq("wberr_mem", mem[9'h1FF], 32'hDEAD_5678);

        // Byte lanes at the top of the buffer.
        dp_txn(1'b0, 11'h7FC, 8'h00, rd8, err, lat);
        check_eq("dp_lane0", {err, rd8}, {1'b0, 8'h78});
        dp_txn(1'b0, 11'h7FF, 8'h00, rd8, err, lat);
        check_eq("dp_lane3", {err, rd8}, {1'b0, 8'hDE});

        // Simultaneous requests with Wishbone as owner.
        exec = 1'b1;
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b0; bus.dp_addr_i = 11'h006;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'h1FF;
        wb_at = 0; dp_at = 0; dp_err_seen = 1'b0; rd32 = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bus.wb_ack_o && wb_at == 0) begin
                wb_at = i; rd32 = bus.wb_dat_o;
                bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
            end
            if (bus.dp_ack_o && dp_at == 0) begin
                dp_at = i; dp_err_seen = bus.dp_err_o;
                bus.dp_req_i = 1'b0;
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.dp_req_i = 1'b0;
        check_eq("sim_wb_at", wb_at, 3);
        check_eq("sim_wb_data", rd32, 32'hDEAD_5678);
        check_eq("sim_dp_at", dp_at, 5);
        check_eq("sim_dp_err", dp_err_seen, 1'b1);

        // exec drops during WAIT of a Wishbone read.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'h1FF;
        step();
        step();
        exec = 1'b0;
        check_eq("tog_wait_owner", owner, 1'b1);
        step();
        check_eq("tog_ack", {bus.wb_ack_o, bus.wb_err_o}, 2'b10);
        check_eq("tog_data", bus.wb_dat_o, 32'hDEAD_5678);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        step();
        check_eq("tog_e3_owner", owner, 1'b1);
        step();
        check_eq("tog_e4_owner", owner, 1'b0);

        // Reset during ISSUE of a data-provider write.
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b1; bus.dp_addr_i = 11'h008; bus.dp_wdata_i = 8'h3C;
        step();
        check_eq("rmid_issue_we", bus.ram_we_o, 4'b0001);
        rst = 1'b1;
        step();
        check_eq("rmid_we", bus.ram_we_o, 4'b0000);
        check_eq("rmid_addr", bus.ram_addr_o, 9'd0);
        check_eq("rmid_resp", {bus.dp_ack_o, bus.dp_err_o, bus.wb_ack_o, bus.wb_err_o, owner}, 5'b00000);
        check_eq("rmid_rdata", {bus.dp_rdata_o, bus.wb_dat_o}, 40'h0);
        rst = 1'b0;
        bus.dp_req_i = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.dp_ack_o) ack = 1'b1;
        end
        check_eq("rmid_no_ack", ack, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/tpm_buf_arbiter.md
# tpm_buf_arbiter

Single-clock arbiter that shares the 512x32 TPM command/response buffer RAM between the byte-wide data-provider (LPC/TIS register side, already synchronized to the system clock) and the CPU Wishbone slave window at 0xF0000800. It replaces clock muxing between LCLK and the Wishbone clock with registered ownership, driven by the TPM `exec` flag. While `exec` is high the CPU owns the buffer; otherwise the data provider owns it. A request from the non-owner is answered with an error and never touches the RAM.

## Interface

- `ADDR_W`, 11: byte address width of the buffer; RAM depth is 2^(ADDR_W-2) words.

- `clk_i` in 1: system clock. The only clock in the block.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `exec_i` in 1: buffer ownership request. 1 = Wishbone side, 0 = data provider.
- `dp_req_i` in 1: data-provider request, held until `dp_ack_o`.
- `dp_we_i` in 1: 1 = write.
- `dp_addr_i` in ADDR_W: byte address.
- `dp_wdata_i` in 8: write byte.
- `dp_rdata_o` out 8: read byte, valid with `dp_ack_o`.
- `dp_ack_o` out 1: one-cycle completion pulse.
- `dp_err_o` out 1: qualifies `dp_ack_o`; 1 = rejected because the data provider is not the owner.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1 each: Wishbone classic slave controls.
- `wb_sel_i` in 4: byte enables.
- `wb_adr_i` in ADDR_W-2: word address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `wb_err_o` out 1: one-cycle error pulse.
- `ram_addr_o` out ADDR_W-2: RAM word address.
- `ram_wdata_o` out 32: RAM write data.
- `ram_we_o` out 4: RAM byte write enables.
- `ram_rdata_i` in 32: RAM read data; synchronous RAM, valid one edge after the address is presented.
- `owner_o` out 1: current owner. 1 = Wishbone.

## Operation

- **FSM states:** IDLE, ISSUE, WAIT, ACK, ERR.
- **Reset:** all outputs go to 0, `owner_o` = 0, state = IDLE.
  - A reset during an in-flight access abandons it: no ack or err is issued, and `ram_we_o` is 0 from that edge on.
- **Owner update:** in IDLE only, `owner_o` <= `exec_i` on every edge. The value latched at acceptance governs the whole transaction, so an `exec_i` toggle mid-access takes effect only after the return to IDLE.
- **Accept condition:** checked in IDLE against the `exec_i` value at that edge.
  - Valid requests are `dp_req_i`, or `wb_cyc_i & wb_stb_i`.
  - The requester matching `exec_i` goes to ISSUE.
  - The non-owner requester goes to ERR.
  - If both request at once, the owner is always served first; the non-owner is errored on the next IDLE pass.
- **ISSUE:** `ram_addr_o`, `ram_wdata_o` and `ram_we_o` are registered at the accepting edge and held for exactly one cycle; `ram_we_o` returns to 0 at the next edge.
- **Data-provider access:**
  - Word address = `dp_addr_i[ADDR_W-1:2]`.
  - Write: `ram_wdata_o` = the byte replicated into all four lanes; `ram_we_o` = 4'b0001 << `dp_addr_i[1:0]`.
  - Read: `ram_we_o` = 0; the byte is taken from lane `addr[1:0]` of the registered address. Lane 0 = bits [7:0].
- **Wishbone access:**
  - Write: `ram_we_o` = `wb_sel_i`. `wb_sel_i` = 0 still completes with ack but writes nothing.
  - Read: `ram_we_o` = 0.
- **WAIT:** the RAM has captured the address; `ram_rdata_i` becomes valid.
- **ACK:** `ram_rdata_i` is registered into `wb_dat_o` / `dp_rdata_o` (reads only; outputs hold their last value otherwise) and the ack is pulsed.
- **ERR:**
  - Data provider: `dp_ack_o` = `dp_err_o` = 1 and `dp_rdata_o` = 8'hFF.
  - Wishbone: `wb_err_o` = 1, `wb_ack_o` = 0.
  - No RAM enable is asserted.
- **Exclusivity:** ack and err are mutually exclusive per port, and only one port responds per transaction.

## Timing

- The request is sampled at edge E0.
- **Normal access:**
  - RAM controls are valid during E0–E1.
  - The RAM captures at E1.
  - Ack and data are high during E2–E3.
  - IDLE is re-entered at E3.
- **Error access:** the err pulse is high during E0–E1 and the FSM returns to IDLE at E1.
- **Back-to-back requests:** no new request is accepted while ack or err is high. A master holding strobe through the ack cycle is not re-accepted; one access completes per 4 cycles minimum.
- **Requester obligation:** requesters hold their request and data stable until ack/err. Dropping the request early does not cancel the in-flight RAM write.

## Test plan

- **Data-provider write and readback:** `exec_i`=0; write 0xA5 to byte address 0x006. Required: `ram_we_o`=4'b0100 and `ram_addr_o`=1 for exactly one cycle, `dp_ack_o` at E2. A following read of 0x006 returns 0xA5 with `dp_err_o`=0.
- **Wishbone partial write:** `exec_i`=1; word 0x1FF, `wb_sel_i`=4'b0011, data 0x12345678. Required: RAM bytes [15:0]=0x5678 with upper bytes unchanged; the readback word reflects this and `wb_ack_o` is a single-cycle pulse.
- **Wrong-owner rejection:**
  - `exec_i`=1 with a data-provider read: `dp_ack_o`=`dp_err_o`=1, `dp_rdata_o`=0xFF, `ram_we_o` never set.
  - `exec_i`=0 with a Wishbone write: `wb_err_o`=1, `wb_ack_o`=0, no RAM write.
- **Simultaneous requests:** `exec_i`=1, both ports request at the same edge. Required: the Wishbone access completes first with ack; the data-provider err follows at the next IDLE.
- **Ownership change and reset mid-access:**
  - Toggle `exec_i` 1→0 during WAIT of a Wishbone read: the read completes with ack and valid data; `owner_o` changes only at the IDLE edge.
  - Assert `rst_i` during ISSUE of a write: no ack, all outputs 0 after that edge, state IDLE.
